// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
//   Parametrised Mealy serial-pattern detector. The last LEN-1 enabled bits
//   are kept in a history register and compared, together with the current
//   input bit, against the active pattern every cycle. Because the whole
//   window is compared, a mismatch never throws away a usable prefix.
//
// Parameters
//   LEN      pattern length in bits (>= 2)
//   PATTERN  pattern loaded at reset; MSB is the first bit received
//   CNT_W    width of the saturating match counter
//
// Ports
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous, active-high reset
//   en         in   sample enable; w is consumed only when en=1
//   w          in   serial data bit
//   overlap    in   1 = overlapping detection, 0 = restart after a match
//   load       in   synchronous pattern load strobe (wins over en)
//   pat_in     in   new pattern, captured when load=1
//   cnt_clr    in   synchronous clear of match_cnt (wins over a match)
//   z          out  Mealy match, combinational from w and state
//   z_reg      out  z delayed by one clock
//   match_cnt  out  saturating number of matches
//   pattern    out  currently active pattern
// ---------------------------------------------------------------------------
module seq_detector #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1101,
    parameter int             CNT_W   = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             w,
    input  logic             overlap,
    input  logic             load,
    input  logic [LEN-1:0]   pat_in,
    input  logic             cnt_clr,
    output logic             z,
    output logic             z_reg,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LEN-1:0]   pattern
);

    // fill counts valid history bits and saturates at LEN-1
    localparam int                FILL_W   = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Fill-count increment that holds at LEN-1.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] v);
        if (v == FILL_MAX) begin
            return v;
        end
        return v + FILL_W'(1);
    endfunction

    logic [LEN-1:0]   pat_reg;
    logic [LEN-2:0]   hist;
    logic [FILL_W-1:0] fill;

    logic [LEN-1:0]   window;
    logic             hist_full;
    logic             restart;

    // The candidate window is the stored history with the live bit appended;
    // its low LEN-1 bits are also the next history value, which keeps the
    // shift well-formed even for LEN=2.
    assign window    = {hist, w};
    assign hist_full = (fill == FILL_MAX);

    assign z       = en & ~load & hist_full & (window == pat_reg);
    assign restart = z & ~overlap;
    assign pattern = pat_reg;

    // Pattern, history and fill state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pat_reg <= PATTERN;
            hist    <= '0;
            fill    <= '0;
        end else if (load) begin
            pat_reg <= pat_in;
            hist    <= '0;
            fill    <= '0;
        end else if (en) begin
            if (restart) begin
                hist <= '0;
                fill <= '0;
            end else begin
                hist <= window[LEN-2:0];
                fill <= fill_inc(fill);
            end
        end
    end

    // Registered copy of the Mealy output
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            z_reg <= 1'b0;
        end else begin
            z_reg <= z;
        end
    end

    // Saturating match counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (z) begin
            match_cnt <= sat_inc(match_cnt);
        end
    end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Parametrised Mealy serial-pattern detector; the successor to the fixed 1101 detector.
- Detects a LEN-bit pattern on serial input w. The pattern is set at elaboration and can be reloaded at runtime.
- Overlapping or non-overlapping detection is selectable; mismatches recover correctly via a history shift register.
- Provides a Mealy output, a registered Moore-style copy, and a saturating match counter. Sits in the serial-input front end of the lab FSM designs.

Parameters:
LEN, 4, pattern length in bits (>= 2)
PATTERN, 4'b1101, reset/default pattern; MSB is the first bit received
CNT_W, 8, match counter width

Ports:
Clock  input  1  single system clock, rising edge
Reset  input  1  asynchronous, active-high reset
en  input  1  sample enable; w is consumed only on edges with en=1
w  input  1  serial data bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
load  input  1  synchronous pattern load strobe
pat_in  input  LEN  new pattern, captured when load=1
cnt_clr  input  1  synchronous clear of match_cnt
z  output  1  Mealy match, combinational from w and state
z_reg  output  1  z registered; one cycle later
match_cnt  output  CNT_W  number of matches, saturating
pattern  output  LEN  currently active pattern

Behaviour:
- Reset is one clock, async active-high. On Reset=1: pat_reg=PATTERN, hist=0 (LEN-1 bits), fill=0, z_reg=0, match_cnt=0. z is then 0 because fill=0.
- State consists of:
  - pat_reg[LEN-1:0];
  - hist[LEN-2:0], the last bits received, newest in bit 0;
  - fill, a count of valid history bits from 0 to LEN-1, saturating.
- z is high when all hold: en=1, load=0, fill==LEN-1, and {hist,w}==pat_reg. It is purely combinational, with no added latency.
- On a rising edge with load=1: pat_reg<=pat_in, hist<=0, fill<=0. The w bit is discarded and z=0 in that cycle. Load has priority over en.
- On a rising edge with load=0 and en=1:
  - if z=1 and overlap=0: hist<=0, fill<=0 (non-overlap restart);
  - otherwise: hist<={hist[LEN-3:0],w} (for LEN=2, hist<=w), and fill<=min(fill+1,LEN-1).
- On a rising edge with load=0 and en=0: all state holds and z=0.
- On every edge, z_reg<=z.
- match_cnt:
  - if cnt_clr=1, it becomes 0; clear wins over a simultaneous match;
  - else if z=1 and match_cnt != all-ones, it increments by 1;
  - at all-ones it holds (saturates, no wrap).
- Mismatch recovery: detection is a full history compare, so partial prefixes are never lost. For pattern 1101, stream 1,1,1,0,1 matches on bit 5.
- overlap may change on any cycle; the value sampled on the match edge decides the restart.
- Reset asserted mid-sequence discards the partial history. The first match then needs LEN fresh enabled bits.
- pattern = pat_reg.

Test Plan:
1. Defaults, overlap=0, en=1, stream 1,1,0,1,1,0,1 -> z=1 only on bit 4; z_reg=1 the cycle after; match_cnt=1.
2. Same stream with overlap=1 -> z=1 on bits 4 and 7; match_cnt=2.
3. Stream 1,1,1,0,1 -> z=1 on bit 5 only (mismatch recovery). Then en=0 for 3 cycles with w toggling -> z=0 and state held. Then 1,1,0,1 -> match on the 4th enabled bit.
4. Pulse load with pat_in=4'b0110 and w=1 -> no z, pattern=0110. Stream 0,1,1,0 -> z on the 4th bit.
5. After 1,1,0, assert Reset between edges, then w=1 -> z=0, pattern=1101, match_cnt=0. First match requires 4 more bits.
6. CNT_W=2, overlap=1, repeated 1101101101101 (4 matches) -> match_cnt goes 1,2,3,3. cnt_clr asserted on a matching edge -> match_cnt=0.
